// File: rtl/sync_tracker.sv
// Registers raw HSync/VSync, keeps column/row counters aligned to the VSync
// assertion edge and tracks frame-length lock with active-video and strobe decode.
module sync_tracker #(
  parameter int TOTAL_COLS    = 1040,
  parameter int TOTAL_ROWS    = 666,
  parameter int ACTIVE_COLS   = 800,
  parameter int ACTIVE_ROWS   = 600,
  parameter int CNT_WIDTH     = 12,
  parameter int HS_ACTIVE_LOW = 0,
  parameter int VS_ACTIVE_LOW = 0,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_HSync,
  input  logic                 i_VSync,
  output logic                 o_HSync,
  output logic                 o_VSync,
  output logic [CNT_WIDTH-1:0] o_Col_Count,
  output logic [CNT_WIDTH-1:0] o_Row_Count,
  output logic                 o_Frame_Start,
  output logic                 o_Line_Start,
  output logic                 o_Active,
  output logic                 o_Locked,
  output logic                 o_Sync_Err
);

  // state     | meaning
  // SEARCH    | no frame reference yet, waiting for the first VSync edge
  // TRACK     | counting consecutive well-formed frames toward lock
  // LOCKED    | frame length confirmed; violations raise o_Sync_Err

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(TOTAL_COLS - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(TOTAL_ROWS - 1);
  localparam logic [CNT_WIDTH-1:0] ACT_COLS = CNT_WIDTH'(ACTIVE_COLS);
  localparam logic [CNT_WIDTH-1:0] ACT_ROWS = CNT_WIDTH'(ACTIVE_ROWS);
  localparam logic [3:0]           LOCK_TGT = 4'(LOCK_FRAMES);
  localparam logic                 VS_POL   = (VS_ACTIVE_LOW != 0);

  // Reject parameter sets the counters or match register cannot represent.
  if ((LOCK_FRAMES < 1) || (LOCK_FRAMES > 15) ||
      ((2 ** CNT_WIDTH) < TOTAL_COLS) || ((2 ** CNT_WIDTH) < TOTAL_ROWS) ||
      (HS_ACTIVE_LOW < 0) || (HS_ACTIVE_LOW > 1) ||
      (VS_ACTIVE_LOW < 0) || (VS_ACTIVE_LOW > 1)) begin : g_bad_params
    $error("sync_tracker: unsupported parameter combination");
  end

  logic [1:0] state;
  logic [3:0] match_cnt;
  logic       vs_now_a;
  logic       vs_reg_a;
  logic       fs;
  logic       frame_end;
  logic       good_frame;
  logic       bad_frame;

  assign vs_now_a   = i_VSync ^ VS_POL;
  assign vs_reg_a   = o_VSync ^ VS_POL;
  assign fs         = vs_now_a & ~vs_reg_a;
  assign frame_end  = (o_Col_Count == COL_LAST) && (o_Row_Count == ROW_LAST);
  assign good_frame = fs & frame_end;
  assign bad_frame  = fs ^ frame_end;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_HSync       <= i_HSync;
      o_VSync       <= i_VSync;
      o_Frame_Start <= fs;
    end
  end

  // The sync edge wins over the free-running wrap regardless of lock state.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Col_Count <= '0;
      o_Row_Count <= '0;
    end else if (fs) begin
      o_Col_Count <= '0;
      o_Row_Count <= '0;
    end else if (o_Col_Count == COL_LAST) begin
      o_Col_Count <= '0;
      if (o_Row_Count == ROW_LAST) begin
        o_Row_Count <= '0;
      end else begin
        o_Row_Count <= o_Row_Count + 1'b1;
      end
    end else begin
      o_Col_Count <= o_Col_Count + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= ST_SEARCH;
      match_cnt  <= '0;
      o_Sync_Err <= 1'b0;
    end else begin
      o_Sync_Err <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (fs) begin
            state     <= ST_TRACK;
            match_cnt <= '0;
          end
        end
        ST_TRACK: begin
          if (good_frame) begin
            match_cnt <= match_cnt + 4'd1;
            if ((match_cnt + 4'd1) == LOCK_TGT) begin
              state <= ST_LOCKED;
            end
          end else if (bad_frame) begin
            match_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (bad_frame) begin
            o_Sync_Err <= 1'b1;
            state      <= ST_TRACK;
            match_cnt  <= '0;
          end
        end
        default: begin
          state     <= ST_SEARCH;
          match_cnt <= '0;
        end
      endcase
    end
  end

  assign o_Locked     = (state == ST_LOCKED);
  assign o_Line_Start = (o_Col_Count == '0);
  assign o_Active     = o_Locked && (o_Col_Count < ACT_COLS) && (o_Row_Count < ACT_ROWS);

endmodule
